// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_ROM,
    REG_TIMER,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Region bounds; limits are inclusive, the timer region is open-ended.
  localparam logic [31:0] RAM_BASE   = 32'h0000_4000;
  localparam logic [31:0] RAM_LIMIT  = 32'h0000_4400;
  localparam logic [31:0] ROM_BASE   = 32'h0000_4600;
  localparam logic [31:0] ROM_LIMIT  = 32'h0000_5000;
  localparam logic [31:0] TIMER_BASE = 32'h0000_5200;

  // Read-mux select encodings as {sel_one, sel_zero}.
  localparam logic [1:0] SEL_RAM   = 2'b01;
  localparam logic [1:0] SEL_ROM   = 2'b10;
  localparam logic [1:0] SEL_TIMER = 2'b00;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  function automatic logic [1:0] region_sel(input region_t r);
    case (r)
      REG_RAM:   return SEL_RAM;
      REG_ROM:   return SEL_ROM;
      REG_TIMER: return SEL_TIMER;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: maps a bus address onto its memory region.
module mem_region_decode
  import mem_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] addr,
  output region_t      region
);

  // Inclusive range compare; anything falling in the gaps is unmapped.
  always_comb begin
    if (addr >= N'(RAM_BASE) && addr <= N'(RAM_LIMIT)) begin
      region = REG_RAM;
    end else if (addr >= N'(ROM_BASE) && addr <= N'(ROM_LIMIT)) begin
      region = REG_ROM;
    end else if (addr >= N'(TIMER_BASE)) begin
      region = REG_TIMER;
    end else begin
      region = REG_NONE;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the data-memory bus (RAM/ROM/timer).
// Optional feature macro: MEM_ARB_ERR_EN -- unmapped accesses and ROM writes
// skip the bus and complete at once with err set.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N          = 32,
  parameter int RAM_WAIT   = 0,
  parameter int ROM_WAIT   = 1,
  parameter int TIMER_WAIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [1:0]   we,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] wdata0,
  input  logic [N-1:0] wdata1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         err,
  output logic [N-1:0] rdata,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  output logic         WEram,
  output logic         WEtimer,
  output logic         sel_zero,
  output logic         sel_one,
  input  logic [N-1:0] mux_rdata
);

  state_t       state, state_next;
  logic         last;
  logic         cur;
  logic         cap_we;
  logic         cap_err;
  region_t      cap_region;
  logic [3:0]   wait_cnt;
  logic [N-1:0] rdata_q;

  logic         any_req;
  logic         winner;
  logic         bad_access;
  logic [N-1:0] win_addr;
  region_t      win_region;

  // On a tie the master that was not served last wins.
  assign any_req  = |req;
  assign winner   = (req == 2'b11) ? ~last : req[1];
  assign win_addr = winner ? addr1 : addr0;

  mem_region_decode #(.N(N)) u_decode (
    .addr   (win_addr),
    .region (win_region)
  );

`ifdef MEM_ARB_ERR_EN
  assign bad_access = (win_region == REG_NONE) || ((win_region == REG_ROM) && we[winner]);
`else
  assign bad_access = 1'b0;
`endif

  function automatic logic [3:0] wait_of(input region_t r);
    case (r)
      REG_RAM:   return 4'(RAM_WAIT);
      REG_ROM:   return 4'(ROM_WAIT);
      REG_TIMER: return 4'(TIMER_WAIT);
      default:   return 4'd0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus outputs; strobes only in the final ACCESS cycle.
  always_comb begin
    state_next          = state;
    gnt                 = 2'b00;
    done                = 2'b00;
    err                 = 1'b0;
    rdata               = '0;
    WEram               = 1'b0;
    WEtimer             = 1'b0;
    {sel_one, sel_zero} = SEL_NONE;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt[winner] = 1'b1;
          state_next  = bad_access ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        {sel_one, sel_zero} = region_sel(cap_region);
        if (wait_cnt == 4'd0) begin
          WEram      = cap_we && (cap_region == REG_RAM);
          WEtimer    = cap_we && (cap_region == REG_TIMER);
          state_next = RESP;
        end
      end
      RESP: begin
        done[cur]  = 1'b1;
        err        = cap_err;
        rdata      = (cap_we || cap_err) ? '0 : rdata_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction capture at grant, wait countdown and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= 1'b1;
      cur        <= 1'b0;
      cap_we     <= 1'b0;
      cap_err    <= 1'b0;
      cap_region <= REG_NONE;
      wait_cnt   <= 4'd0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last       <= winner;
            cur        <= winner;
            cap_we     <= we[winner];
            cap_err    <= bad_access;
            cap_region <= win_region;
            wait_cnt   <= wait_of(win_region);
            bus_addr   <= win_addr;
            bus_wdata  <= winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            rdata_q <= mux_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; honours MEM_ARB_ERR_EN when defined.
module tb_mem_bus_arbiter;

  localparam int N       = 32;
  localparam int RAM_W   = 0;
  localparam int ROM_W   = 1;
  localparam int TIMER_W = 0;
`ifdef MEM_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [1:0]   we = 2'b00;
  logic [N-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]   gnt, done;
  logic         err;
  logic [N-1:0] rdata, bus_addr, bus_wdata, mux_rdata;
  logic         WEram, WEtimer, sel_zero, sel_one;

  int cyc = 0;

  // Read mux stand-in: address in the low half, a per-cycle salt in the high half.
  assign mux_rdata = bus_addr ^ {cyc[15:0], 16'h0000};

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .N(N), .RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W), .TIMER_WAIT(TIMER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .WEram(WEram), .WEtimer(WEtimer), .sel_zero(sel_zero), .sel_one(sel_one),
    .mux_rdata(mux_rdata)
  );

  typedef struct {
    int          master;
    logic        rd;
    logic [15:0] alow;
    int          latency;
    logic        err;
    logic        wer;
    logic        wet;
    logic [31:0] wdata;
    logic [1:0]  sel;
    int          sel_cycles;
  } exp_t;

  typedef struct {
    int master;
    int gap;
  } gexp_t;

  typedef struct {
    int          m;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } stim_t;

  exp_t  sb_q[$];
  gexp_t gnt_q[$];
  stim_t tbl[$];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Reference region map: 0 RAM, 1 ROM, 2 timer, 3 unmapped.
  function automatic int region_of(input logic [31:0] a);
    if (a < 32'h4000) return 3;
    if (a <= 32'h4400) return 0;
    if (a < 32'h4600) return 3;
    if (a <= 32'h5000) return 1;
    if (a < 32'h5200) return 3;
    return 2;
  endfunction

  function automatic exp_t make_exp(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   r;
    int   wt;
    r  = region_of(a);
    wt = (r == 0) ? RAM_W : (r == 1) ? ROM_W : (r == 2) ? TIMER_W : 0;
    e.master     = m;
    e.alow       = a[15:0];
    e.wdata      = d;
    e.err        = ERR_EN && ((r == 3) || ((r == 1) && w));
    e.rd         = !w && !e.err;
    e.latency    = e.err ? 1 : 2 + wt;
    e.wer        = !e.err && w && (r == 0);
    e.wet        = !e.err && w && (r == 2);
    e.sel        = e.err ? 2'b11 : (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b00 : 2'b11;
    e.sel_cycles = (e.err || (r == 3)) ? 0 : wt + 1;
    return e;
  endfunction

  // Monitor state for the single in-flight transaction.
  int          g_cyc = 0;
  int          sel_cnt = 0, wer_cnt = 0, wet_cnt = 0, strobe_cyc = -1;
  logic [1:0]  sel_first = 2'b00;
  logic [31:0] strobe_wdata = '0;
  int          dm, idx, g_master;
  exp_t        mon_e;
  gexp_t       mon_g;

  // Sample on the falling edge; pop the scoreboard whenever done fires.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 2'b00) begin
        g_master = gnt[1] ? 1 : 0;
        if (gnt_q.size() > 0) begin
          mon_g = gnt_q.pop_front();
          checkOutput("gnt_order", g_master, mon_g.master);
          if (mon_g.gap >= 0) checkOutput("gnt_gap", cyc - g_cyc, mon_g.gap);
        end
        g_cyc      = cyc;
        sel_cnt    = 0;
        wer_cnt    = 0;
        wet_cnt    = 0;
        strobe_cyc = -1;
        sel_first  = 2'bxx;
      end else begin
        if (cyc == g_cyc + 1) sel_first = {sel_one, sel_zero};
        if ({sel_one, sel_zero} != 2'b11) sel_cnt++;
        if (WEram) begin wer_cnt++; strobe_cyc = cyc; strobe_wdata = bus_wdata; end
        if (WEtimer) begin wet_cnt++; strobe_cyc = cyc; strobe_wdata = bus_wdata; end
        if (done != 2'b00) begin
          dm  = done[1] ? 1 : 0;
          idx = -1;
          foreach (sb_q[i]) if (idx < 0 && sb_q[i].master == dm) idx = i;
          if (idx < 0) begin
            checkOutput("unexpected_done", {30'd0, done}, 32'd0);
          end else begin
            mon_e = sb_q[idx];
            sb_q.delete(idx);
            checkOutput("latency", cyc - g_cyc, mon_e.latency);
            checkOutput("rdata", rdata, mon_e.rd ? {cyc[15:0], mon_e.alow} : 32'd0);
            checkOutput("err", {31'd0, err}, {31'd0, mon_e.err});
            checkOutput("we_ram_pulses", wer_cnt, {31'd0, mon_e.wer});
            checkOutput("we_timer_pulses", wet_cnt, {31'd0, mon_e.wet});
            checkOutput("sel_first", {30'd0, sel_first}, {30'd0, mon_e.sel});
            checkOutput("sel_cycles", sel_cnt, mon_e.sel_cycles);
            if (mon_e.wer || mon_e.wet) begin
              checkOutput("strobe_cycle", strobe_cyc, cyc - 1);
              checkOutput("strobe_wdata", strobe_wdata, mon_e.wdata);
            end
          end
        end
      end
    end
    cyc <= cyc + 1;
  end

  // Drive one request, hold it until granted, then release.
  task automatic applyStimulus(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    sb_q.push_back(make_exp(m, w, a, d));
    if (m == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    we[m]  = w;
    req[m] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[m] && n < 60);
    if (!gnt[m]) checkOutput("gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req[m] = 1'b0;
    we[m]  = 1'b0;
  endtask

  // Wait for all outstanding transactions to complete.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gnt_done", {28'd0, gnt, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
    checkOutput("rst_strobes", {30'd0, WEram, WEtimer}, 32'd0);
    checkOutput("rst_sel", {30'd0, sel_one, sel_zero}, 32'd3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] round-robin with both masters requesting");
    gnt_q.push_back('{0, -1});
    gnt_q.push_back('{1, 3});
    gnt_q.push_back('{0, 3});
    gnt_q.push_back('{1, 3});
    gnt_q.push_back('{0, 3});
    gnt_q.push_back('{1, 3});
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 32'h4000 + 32'(i * 4), 32'd0);
      end
      begin
        for (int j = 0; j < 3; j++) applyStimulus(1, 1'b0, 32'h4100 + 32'(j * 4), 32'd0);
      end
    join
    drain();
    checkOutput("gnt_q_drain", gnt_q.size(), 0);

    $display("[TB] single transactions across regions and boundaries");
    tbl.push_back('{0, 1'b0, 32'h0000_4010, 32'h0});
    tbl.push_back('{1, 1'b1, 32'h0000_5200, 32'h0000_DEAD});
    tbl.push_back('{0, 1'b0, 32'h0000_4800, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0000_4500, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h0000_4600, 32'h0000_BEEF});
    tbl.push_back('{1, 1'b0, 32'h0000_4400, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h0000_4401, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h0000_4000, 32'h1234_5678});
    tbl.push_back('{1, 1'b0, 32'h0000_5000, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0000_51FF, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h0000_3FFF, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h0000_6000, 32'h0});
    tbl.push_back('{0, 1'b1, 32'h0000_45FF, 32'h0000_0BAD});
    foreach (tbl[k]) begin
      applyStimulus(tbl[k].m, tbl[k].w, tbl[k].a, tbl[k].d);
      drain();
    end

    $display("[TB] reset in the middle of a RAM write");
    addr0  = 32'h0000_4020;
    wdata0 = 32'h0000_CAFE;
    we[0]  = 1'b1;
    req[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[0] && n < 20);
    checkOutput("rst_mid_gnt", {31'd0, gnt[0]}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 2'b00;
    we    = 2'b00;
    #1;
    checkOutput("rst_mid_strobes_done", {28'd0, WEram, WEtimer, done}, 32'd0);
    checkOutput("rst_mid_sel", {30'd0, sel_one, sel_zero}, 32'd3);
    checkOutput("rst_mid_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_mid_bus_wdata", bus_wdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_mid_hold", {28'd0, WEram, WEtimer, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 32'h0000_4030, 32'h0);
    drain();
    applyStimulus(0, 1'b1, 32'h0000_4024, 32'h0000_F00D);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
